// File: rtl/mem_port_arbiter_pkg.sv
// mem_arb_pkg
//   Shared definitions for the two-port Memoria arbiter: the FSM state type,
//   the port identifiers carried on grant_id, and a small word-select helper
//   used when latching the winning requester's fields.
//   No ports (package).

package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } arb_state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_AUX = 1'b1;

    // Picks the port-1 copy of a field when sel is PORT_AUX, else port 0.
    function automatic logic [31:0] pick_word(input logic sel,
                                              input logic [31:0] word0,
                                              input logic [31:0] word1);
        return (sel == PORT_AUX) ? word1 : word0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if
//   Bundles the two requester ports, the shared read-data return and the
//   Memoria-side bus of the arbiter.
//   Ports (signals):
//     req0/we0/addr0/wdata0, ack0   port 0 (CPU) request fields and completion
//     req1/we1/addr1/wdata1, ack1   port 1 (aux master) request fields and completion
//     rdata                         read data, valid in the ack cycle of a read
//     mem_addr/mem_wr/mem_wdata     drive Memoria Address/Wr/DataIn
//     mem_rdata                     Memoria DataOut
//     busy/grant_id                 arbiter status
//   Modports:
//     slave   the arbiter itself
//     master  its environment: both requesters plus the Memoria read-data return

interface mem_port_arbiter_if;

    logic        req0;
    logic        we0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        ack0;

    logic        req1;
    logic        we1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        ack1;

    logic [31:0] rdata;

    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic        busy;
    logic        grant_id;

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, ack1, rdata,
        output mem_addr, mem_wr, mem_wdata,
        output busy, grant_id
    );

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, ack1, rdata,
        input  mem_addr, mem_wr, mem_wdata,
        input  busy, grant_id
    );

endinterface

// File: rtl/mem_port_arbiter_select.sv
// mem_arb_select
//   Grant decision for the arbiter plus the port-1 starvation counter.
//   Port 0 wins ties until port 1 has lost STARVE_LIMIT arbitrations in a
//   row, after which port 1 is forced through once.
//   Ports:
//     clock, reset   rising-edge clock, synchronous active-high reset
//     req0, req1     live request lines of the two ports
//     arbitrate      high while the parent FSM is in IDLE and may grant
//     grant_port     combinational winner (PORT_CPU / PORT_AUX)

module mem_arb_select #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic arbitrate,
    output logic grant_port
);

    import mem_arb_pkg::*;

    localparam int               CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0]    LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] starve;

    // Port 1 wins when it is alone or has been starved long enough.
    always_comb begin
        grant_port = PORT_CPU;
        if (req1 && (!req0 || (starve >= LIMIT))) begin
            grant_port = PORT_AUX;
        end
    end

    // Count consecutive IDLE-cycle losses of a waiting port 1, saturating at
    // the limit; any port-1 win or an absent port-1 request clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve <= '0;
        end else if (arbitrate) begin
            if (!req1 || (grant_port == PORT_AUX)) begin
                starve <= '0;
            end else if (starve < LIMIT) begin
                starve <= starve + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares single-port Memoria between the CPU (port 0) and an aux master
//   (port 1). One transaction in flight: the winner's fields are latched in
//   IDLE, the write strobe is pulsed for exactly the ACCESS cycle, reads wait
//   MEM_RD_LAT cycles before capturing mem_rdata, and RESP pulses the ack.
//   All outputs are registered.
//   Ports:
//     clock   rising-edge clock
//     reset   synchronous, active-high; abandons any transaction without ack
//     bus     mem_port_arbiter_if.slave (requesters, Memoria bus, status)

module mem_port_arbiter #(
    parameter int MEM_RD_LAT   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    mem_port_arbiter_if.slave    bus
);

    import mem_arb_pkg::*;

    localparam int            LW       = $clog2(MEM_RD_LAT + 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(MEM_RD_LAT);

    arb_state_t    state;
    logic [LW-1:0] lat_cnt;
    logic          we_lat;
    logic          grant_port;

    logic          ack0_r;
    logic          ack1_r;
    logic [31:0]   rdata_r;
    logic [31:0]   mem_addr_r;
    logic          mem_wr_r;
    logic [31:0]   mem_wdata_r;
    logic          busy_r;
    logic          grant_id_r;

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clock      (clock),
        .reset      (reset),
        .req0       (bus.req0),
        .req1       (bus.req1),
        .arbitrate  (state == IDLE),
        .grant_port (grant_port)
    );

    // Transaction sequencer. Fields are copied into mem_addr/mem_wdata/we_lat
    // at grant time so later changes on the request lines have no effect.
    // mem_addr is left untouched after ACCESS so Memoria sees a stable address
    // for the whole read latency and through RESP.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            lat_cnt     <= '0;
            we_lat      <= 1'b0;
            ack0_r      <= 1'b0;
            ack1_r      <= 1'b0;
            rdata_r     <= '0;
            mem_addr_r  <= '0;
            mem_wr_r    <= 1'b0;
            mem_wdata_r <= '0;
            busy_r      <= 1'b0;
            grant_id_r  <= PORT_CPU;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        grant_id_r  <= grant_port;
                        mem_addr_r  <= pick_word(grant_port, bus.addr0, bus.addr1);
                        mem_wdata_r <= pick_word(grant_port, bus.wdata0, bus.wdata1);
                        we_lat      <= (grant_port == PORT_AUX) ? bus.we1 : bus.we0;
                        mem_wr_r    <= (grant_port == PORT_AUX) ? bus.we1 : bus.we0;
                        busy_r      <= 1'b1;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_wr_r <= 1'b0;
                    if (we_lat) begin
                        ack0_r <= (grant_id_r == PORT_CPU);
                        ack1_r <= (grant_id_r == PORT_AUX);
                        state  <= RESP;
                    end else begin
                        lat_cnt <= LW'(1);
                        state   <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_cnt == LAT_LAST) begin
                        rdata_r <= bus.mem_rdata;
                        ack0_r  <= (grant_id_r == PORT_CPU);
                        ack1_r  <= (grant_id_r == PORT_AUX);
                        state   <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RESP: begin
                    ack0_r <= 1'b0;
                    ack1_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = ack0_r;
    assign bus.ack1      = ack1_r;
    assign bus.rdata     = rdata_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wr    = mem_wr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.busy      = busy_r;
    assign bus.grant_id  = grant_id_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Scoreboarded bench for mem_port_arbiter. A transaction-level reference
//   model decides, from the request lines at each free arbitration cycle, who
//   wins and when the ack, write strobe and read data must appear; a monitor
//   compares the DUT against those expectations every cycle. A Memoria model
//   only returns valid data once the address has been stable long enough.
//   Ports: none (top-level bench).

module tb_mem_port_arbiter;

    localparam int MEM_RD_LAT   = 2;
    localparam int STARVE_LIMIT = 4;

    typedef struct {
        int          port;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        longint      ack_cycle;
    } exp_t;

    logic clock = 1'b0;
    logic reset;

    mem_port_arbiter_if bus ();

    mem_port_arbiter #(
        .MEM_RD_LAT   (MEM_RD_LAT),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          checks   = 0;
    int          failures = 0;
    longint      cyc      = 0;
    bit          sb_on    = 1'b0;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dev_mem [logic [31:0]];

    longint      free_at    = 0;
    longint      busy_from  = 1;
    longint      busy_to    = 0;
    longint      wr_cycle   = -1;
    int          starve     = 0;
    logic        last_port  = 1'b0;
    logic [31:0] last_rdata = '0;
    logic [31:0] cur_addr   = '0;
    logic [31:0] cur_wdata  = '0;
    logic        m_r0, m_r1, m_p;
    logic        exp_busy;

    logic [31:0] dev_last   = '0;
    int          dev_stable = 0;

    function automatic logic [31:0] init_data(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_data(a);
    endfunction

    function automatic logic [31:0] dev_read(input logic [31:0] a);
        return dev_mem.exists(a) ? dev_mem[a] : init_data(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s at cycle %0d: actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Records one granted transaction: when its ack is due, what read data it
    // must return, and the window in which the arbiter counts as busy.
    task automatic model_grant(input logic p);
        exp_t e;
        e.port  = int'(p);
        e.we    = p ? bus.we1 : bus.we0;
        e.addr  = p ? bus.addr1 : bus.addr0;
        e.wdata = p ? bus.wdata1 : bus.wdata0;
        if (e.we) begin
            ref_mem[e.addr] = e.wdata;
            e.ack_cycle     = cyc + 2;
            wr_cycle        = cyc + 1;
        end else begin
            last_rdata  = ref_read(e.addr);
            e.ack_cycle = cyc + 2 + MEM_RD_LAT;
            wr_cycle    = -1;
        end
        e.rdata   = last_rdata;
        busy_from = cyc + 1;
        busy_to   = e.ack_cycle;
        free_at   = e.ack_cycle + 1;
        last_port = p;
        cur_addr  = e.addr;
        cur_wdata = e.wdata;
        exp_q.push_back(e);
    endtask

    // Reference model: at every clock edge where the arbiter is free it sees
    // the same request lines the DUT samples and applies the priority and
    // starvation rules; a reset edge discards everything in flight.
    always @(posedge clock) begin
        if (reset) begin
            exp_q.delete();
            free_at    = cyc + 1;
            busy_from  = 1;
            busy_to    = 0;
            wr_cycle   = -1;
            starve     = 0;
            last_port  = 1'b0;
            last_rdata = '0;
        end else if (cyc >= free_at) begin
            m_r0 = bus.req0;
            m_r1 = bus.req1;
            m_p  = m_r1 && (!m_r0 || (starve >= STARVE_LIMIT));
            if (m_r0 || m_r1) begin
                model_grant(m_p);
            end
            if (!m_r1 || m_p) begin
                starve = 0;
            end else if (starve < STARVE_LIMIT) begin
                starve = starve + 1;
            end
        end
        cyc = cyc + 1;
    end

    // Memoria stand-in: writes land on the strobe, and read data is only
    // correct after the address has been held for more than MEM_RD_LAT edges,
    // so an early capture returns a recognisable junk word.
    always @(negedge clock) begin
        if (bus.mem_wr === 1'b1) begin
            dev_mem[bus.mem_addr] = bus.mem_wdata;
        end
        if (bus.mem_addr === dev_last) begin
            dev_stable = dev_stable + 1;
        end else begin
            dev_stable = 1;
        end
        dev_last      = bus.mem_addr;
        bus.mem_rdata = (dev_stable > MEM_RD_LAT) ? dev_read(bus.mem_addr) : 32'h0BAD_F00D;
    end

    // Monitor: compares status, strobe, address hold and acks every cycle and
    // retires the oldest expected transaction when its ack cycle arrives.
    always @(negedge clock) begin
        if (sb_on) begin
            exp_busy = (cyc >= busy_from) && (cyc <= busy_to);
            checkOutput("busy", 32'(bus.busy), 32'(exp_busy));
            checkOutput("mem_wr", 32'(bus.mem_wr), 32'(cyc == wr_cycle));
            if (cyc == wr_cycle) begin
                checkOutput("wr_addr", bus.mem_addr, cur_addr);
                checkOutput("wr_data", bus.mem_wdata, cur_wdata);
            end
            if (exp_busy) begin
                checkOutput("mem_addr_hold", bus.mem_addr, cur_addr);
            end
            checkOutput("grant_id", 32'(bus.grant_id), 32'(last_port));
            if ((exp_q.size() > 0) && (exp_q[0].ack_cycle == cyc)) begin
                checkOutput("ack0", 32'(bus.ack0), 32'(exp_q[0].port == 0));
                checkOutput("ack1", 32'(bus.ack1), 32'(exp_q[0].port == 1));
                checkOutput("rdata", bus.rdata, exp_q[0].rdata);
                void'(exp_q.pop_front());
            end else begin
                checkOutput("no_ack", {30'b0, bus.ack0, bus.ack1}, 32'd0);
            end
        end
    end

    task automatic drive_port(input int p, input logic r, input logic w,
                              input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end else begin
            bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end
    endtask

    function automatic logic ack_of(input int p);
        return (p == 0) ? bus.ack0 : bus.ack1;
    endfunction

    function automatic bit owner(input int p);
        return sb_on && (cyc >= busy_from) && (cyc <= busy_to) && (int'(last_port) == p);
    endfunction

    // Waits (bounded) for this port's ack. mode 1 scrambles the request
    // fields at random while the port owns the arbiter, mode 2 every cycle.
    task automatic wait_ack(input int p, input int mode, output logic [31:0] rd, output longint at);
        bit got;
        got = 1'b0;
        rd  = '0;
        at  = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clock);
            if (ack_of(p) === 1'b1) begin
                got = 1'b1;
                rd  = bus.rdata;
                at  = cyc;
            end else if ((mode != 0) && owner(p) && ((mode == 2) || ($urandom_range(0, 2) == 0))) begin
                drive_port(p, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL ack_timeout port%0d: actual=no ack required=ack within 200 cycles", p);
        end
    endtask

    task automatic applyStimulus(input int p, input logic w, input logic [31:0] a,
                                 input logic [31:0] d, input int mode,
                                 output logic [31:0] rd, output longint latency);
        longint t0;
        longint at;
        @(negedge clock);
        drive_port(p, 1'b1, w, a, d);
        t0 = cyc;
        wait_ack(p, mode, rd, at);
        drive_port(p, 1'b0, w, a, d);
        latency = at - t0;
    endtask

    task automatic run_port(input int p, input int n, input bit back_to_back);
        logic [31:0] rd;
        longint      at;
        int          gap;
        @(negedge clock);
        for (int i = 0; i < n; i++) begin
            drive_port(p, 1'b1, 1'($urandom_range(0, 1)),
                       32'h1000 + 32'($urandom_range(0, 15)) * 4, $urandom);
            wait_ack(p, 1, rd, at);
            gap = back_to_back ? 0 : int'($urandom_range(0, 4));
            if (gap > 0) begin
                drive_port(p, 1'b0, 1'b0, '0, '0);
                repeat (gap) @(negedge clock);
            end
        end
        drive_port(p, 1'b0, 1'b0, '0, '0);
    endtask

    // Directed scenarios first, then randomized traffic on both ports.
    initial begin
        logic [31:0] rd;
        longint      lat;
        longint      t0;
        longint      at0;
        longint      at1;

        reset = 1'b1;
        drive_port(0, 1'b0, 1'b0, '0, '0);
        drive_port(1, 1'b0, 1'b0, '0, '0);
        ref_mem[32'h40] = 32'hDEAD_BEEF;
        dev_mem[32'h40] = 32'hDEAD_BEEF;

        repeat (3) @(negedge clock);
        checkOutput("rst_ack0", 32'(bus.ack0), 32'd0);
        checkOutput("rst_ack1", 32'(bus.ack1), 32'd0);
        checkOutput("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_grant_id", 32'(bus.grant_id), 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput("rst_rdata", bus.rdata, 32'd0);
        reset = 1'b0;
        sb_on = 1'b1;

        $display("[TB] port-0 read of preloaded word");
        applyStimulus(0, 1'b0, 32'h40, 32'h0, 0, rd, lat);
        checkOutput("t1_latency", 32'(lat), 32'(2 + MEM_RD_LAT));
        checkOutput("t1_rdata", rd, 32'hDEAD_BEEF);

        $display("[TB] port-1 write");
        applyStimulus(1, 1'b1, 32'h80, 32'h1234, 0, rd, lat);
        checkOutput("t2_latency", 32'(lat), 32'd2);
        checkOutput("t2_rdata_held", rd, 32'hDEAD_BEEF);

        $display("[TB] simultaneous requests");
        @(negedge clock);
        drive_port(0, 1'b1, 1'b0, 32'h50, 32'h0);
        drive_port(1, 1'b1, 1'b1, 32'h54, 32'hCAFE);
        t0 = cyc;
        wait_ack(0, 0, rd, at0);
        drive_port(0, 1'b0, 1'b0, 32'h50, 32'h0);
        wait_ack(1, 0, rd, at1);
        drive_port(1, 1'b0, 1'b1, 32'h54, 32'hCAFE);
        checkOutput("t4_port0_first", 32'(at0 - t0), 32'(2 + MEM_RD_LAT));
        checkOutput("t4_port1_next", 32'(at1 - at0), 32'd3);

        $display("[TB] reset during read wait");
        @(negedge clock);
        drive_port(0, 1'b1, 1'b0, 32'h60, 32'h0);
        repeat (2) @(negedge clock);
        checkOutput("t5_busy_before", 32'(bus.busy), 32'd1);
        reset = 1'b1;
        drive_port(0, 1'b0, 1'b0, 32'h60, 32'h0);
        @(negedge clock);
        checkOutput("t5_busy_after", 32'(bus.busy), 32'd0);
        checkOutput("t5_ack0_after", 32'(bus.ack0), 32'd0);
        checkOutput("t5_mem_wr_after", 32'(bus.mem_wr), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        applyStimulus(0, 1'b0, 32'h48, 32'h0, 0, rd, lat);
        checkOutput("t5_resume_latency", 32'(lat), 32'(2 + MEM_RD_LAT));
        checkOutput("t5_resume_rdata", rd, init_data(32'h48));

        $display("[TB] request fields scrambled while granted");
        applyStimulus(0, 1'b0, 32'h44, 32'h0, 2, rd, lat);
        checkOutput("t6_rdata", rd, init_data(32'h44));

        $display("[TB] random traffic");
        fork
            run_port(0, 30, 1'b0);
            run_port(1, 30, 1'b0);
        join

        $display("[TB] back-to-back traffic on both ports");
        fork
            run_port(0, 15, 1'b1);
            run_port(1, 6, 1'b1);
        join

        repeat (10) @(negedge clock);
        checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
